// File: rtl/bus_cycle_master_if.sv
// Request/response and system-bus signal bundle for bus_cycle_master.
// The master modport is the bus-cycle initiator; the slave modport is the
// requester side (it also supplies bus_din from the decoder).
interface bus_cycle_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_inta;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [19:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_iom;
  logic        bus_rd_n;
  logic        bus_wr_n;
  logic        bus_inta_n;
  logic [7:0]  bus_din;

  modport master (
    input  req_valid, req_op, req_inta, req_addr, req_wdata, bus_din,
    output req_ready, rsp_valid, rsp_rdata,
    output bus_addr, bus_dout, bus_iom, bus_rd_n, bus_wr_n, bus_inta_n
  );

  modport slave (
    output req_valid, req_op, req_inta, req_addr, req_wdata, bus_din,
    input  req_ready, rsp_valid, rsp_rdata,
    input  bus_addr, bus_dout, bus_iom, bus_rd_n, bus_wr_n, bus_inta_n
  );
endinterface

// File: rtl/bus_cycle_master.sv
// 8088-style bus cycle initiator: runs T1-T4 (plus Tw) memory/IO read and
// write cycles and the two-pulse interrupt-acknowledge sequence on behalf
// of a valid/ready requester.
module bus_cycle_master #(
  parameter int WAIT_STATES = 0,
  parameter int INTA_IDLE   = 2
) (
  input  logic               clk,
  input  logic               rst,
  bus_cycle_master_if.master bus
);

  // Counter must reach both the Tw count and the AGAP count.
  localparam int CNT_MAX = (WAIT_STATES > INTA_IDLE) ?
                           ((WAIT_STATES > 1) ? WAIT_STATES : 1) :
                           ((INTA_IDLE   > 1) ? INTA_IDLE   : 1);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_TW,
    S_T4,
    S_AGAP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   wcnt;
  logic               pulse_q;   // 0 = first INTA pulse, 1 = second
  logic               inta_q;
  logic               wr_q;

  logic               rsp_valid_q;
  logic [7:0]         rsp_rdata_q;
  logic [19:0]        addr_q;
  logic [7:0]         dout_q;
  logic               iom_q;
  logic               rd_n_q;
  logic               wr_n_q;
  logic               inta_n_q;

  logic               last_low;  // current cycle is the last one with strobe low
  logic               final_pulse;

  // Identify the edge that ends the strobe-low window.
  always_comb begin
    last_low = 1'b0;
    if (state == S_T3 && WAIT_STATES == 0)
      last_low = 1'b1;
    else if (state == S_TW && wcnt == '0)
      last_low = 1'b1;
  end

  // Non-INTA cycles complete on their only pulse; INTA on its second.
  assign final_pulse = !inta_q || pulse_q;

  // Bus cycle sequencer with registered strobes, address and response.
  // NOTE: every assignment here is non-blocking so all flops update from
  // the same pre-edge values; blocking assignments would order-couple them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      pulse_q     <= 1'b0;
      inta_q      <= 1'b0;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      addr_q      <= 20'h0;
      dout_q      <= 8'h00;
      iom_q       <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      inta_n_q    <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            inta_q  <= bus.req_inta;
            wr_q    <= bus.req_op[0];
            pulse_q <= 1'b0;
            if (bus.req_inta) begin
              addr_q <= 20'h0;
              iom_q  <= 1'b0;
            end else begin
              iom_q  <= bus.req_op[1];
              addr_q <= bus.req_op[1] ? {4'h0, bus.req_addr[15:0]} : bus.req_addr;
              if (bus.req_op[0])
                dout_q <= bus.req_wdata;
            end
            state <= S_T1;
          end
        end

        S_T1: begin
          if (inta_q)    inta_n_q <= 1'b0;
          else if (wr_q) wr_n_q   <= 1'b0;
          else           rd_n_q   <= 1'b0;
          state <= S_T2;
        end

        S_T2: state <= S_T3;

        S_T3: begin
          if (last_low) begin
            state <= S_T4;
          end else begin
            wcnt  <= CNT_W'(WAIT_STATES - 1);
            state <= S_TW;
          end
        end

        S_TW: begin
          if (last_low) state <= S_T4;
          else          wcnt  <= wcnt - CNT_W'(1);
        end

        S_T4: begin
          if (!final_pulse) begin
            pulse_q <= 1'b1;
            if (INTA_IDLE > 0) begin
              wcnt  <= CNT_W'(INTA_IDLE - 1);
              state <= S_AGAP;
            end else begin
              state <= S_T1;
            end
          end else begin
            state <= S_IDLE;
          end
        end

        S_AGAP: begin
          if (wcnt == '0) state <= S_T1;
          else            wcnt  <= wcnt - CNT_W'(1);
        end

        default: state <= S_IDLE;
      endcase

      // Close the strobe window: release strobes, capture read/vector data
      // and flag completion for the T4 that follows.
      if (last_low) begin
        rd_n_q   <= 1'b1;
        wr_n_q   <= 1'b1;
        inta_n_q <= 1'b1;
        if (final_pulse && (inta_q || !wr_q))
          rsp_rdata_q <= bus.bus_din;
        if (final_pulse)
          rsp_valid_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready  = (state == S_IDLE) && !rst;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.bus_addr   = addr_q;
  assign bus.bus_dout   = dout_q;
  assign bus.bus_iom    = iom_q;
  assign bus.bus_rd_n   = rd_n_q;
  assign bus.bus_wr_n   = wr_n_q;
  assign bus.bus_inta_n = inta_n_q;

endmodule

// File: tb/tb_bus_cycle_master.sv
// Directed bench for bus_cycle_master: one DUT with no wait states and one
// with two wait states, sharing clock, reset and request fields.
module tb_bus_cycle_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        t_valid0 = 1'b0;
  logic        t_valid2 = 1'b0;
  logic [1:0]  t_op     = 2'b00;
  logic        t_inta   = 1'b0;
  logic [19:0] t_addr   = 20'h0;
  logic [7:0]  t_wdata  = 8'h00;
  logic [7:0]  t_din    = 8'h00;

  logic [7:0]  din_tab [0:31];
  logic        rd_tr   [0:31];
  logic        wr_tr   [0:31];
  logic        inta_tr [0:31];
  logic        val_tr  [0:31];
  logic        rdy_tr  [0:31];
  logic        iom_tr  [0:31];
  logic [19:0] addr_tr [0:31];
  logic [7:0]  dout_tr [0:31];
  logic [7:0]  rdat_tr [0:31];

  bus_cycle_master_if if0 ();
  bus_cycle_master_if if2 ();

  assign if0.req_valid = t_valid0;
  assign if0.req_op    = t_op;
  assign if0.req_inta  = t_inta;
  assign if0.req_addr  = t_addr;
  assign if0.req_wdata = t_wdata;
  assign if0.bus_din   = t_din;

  assign if2.req_valid = t_valid2;
  assign if2.req_op    = t_op;
  assign if2.req_inta  = t_inta;
  assign if2.req_addr  = t_addr;
  assign if2.req_wdata = t_wdata;
  assign if2.bus_din   = t_din;

  bus_cycle_master #(.WAIT_STATES(0), .INTA_IDLE(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.master)
  );

  bus_cycle_master #(.WAIT_STATES(2), .INTA_IDLE(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Issue one request to the selected DUT, then record n cycles after the
  // accepting edge (index i = cycle k+i), driving bus_din from din_tab.
  task automatic issue(input bit sel, input logic [1:0] op, input logic inta,
                       input logic [19:0] addr, input logic [7:0] wd, input int n);
    bit ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk);
      ok = sel ? if2.req_ready : if0.req_ready;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_ready_timeout: req_ready stayed 0, required 1");
    end
    t_op = op; t_inta = inta; t_addr = addr; t_wdata = wd;
    t_din = din_tab[0];
    if (sel) t_valid2 = 1'b1; else t_valid0 = 1'b1;
    @(posedge clk);
    #1;
    t_valid0 = 1'b0; t_valid2 = 1'b0;
    // Scramble request fields to show they were latched at acceptance.
    t_op = ~op; t_inta = ~inta; t_addr = ~addr; t_wdata = ~wd;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (sel) begin
        rd_tr[i] = if2.bus_rd_n; wr_tr[i] = if2.bus_wr_n; inta_tr[i] = if2.bus_inta_n;
        val_tr[i] = if2.rsp_valid; rdy_tr[i] = if2.req_ready; iom_tr[i] = if2.bus_iom;
        addr_tr[i] = if2.bus_addr; dout_tr[i] = if2.bus_dout; rdat_tr[i] = if2.rsp_rdata;
      end else begin
        rd_tr[i] = if0.bus_rd_n; wr_tr[i] = if0.bus_wr_n; inta_tr[i] = if0.bus_inta_n;
        val_tr[i] = if0.rsp_valid; rdy_tr[i] = if0.req_ready; iom_tr[i] = if0.bus_iom;
        addr_tr[i] = if0.bus_addr; dout_tr[i] = if0.bus_dout; rdat_tr[i] = if0.rsp_rdata;
      end
      t_din = din_tab[i];
    end
  endtask

  task automatic fill_din(input logic [7:0] v);
    for (int i = 0; i < 32; i++) din_tab[i] = v;
  endtask

  task automatic test_reset;
    t_valid0 = 1'b1;  // requested during reset: must not be accepted
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (if0.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", if0.req_ready); end
    checks++;
    if ({if0.bus_rd_n, if0.bus_wr_n, if0.bus_inta_n, if0.rsp_valid} !== 4'b1110) begin
      errors++; $display("FAIL reset_strobes: rd/wr/inta/valid got %b want 1110",
                         {if0.bus_rd_n, if0.bus_wr_n, if0.bus_inta_n, if0.rsp_valid});
    end
    checks++;
    if ({if0.bus_addr, if0.bus_dout, if0.rsp_rdata, if0.bus_iom} !== 37'h0) begin
      errors++; $display("FAIL reset_regs: addr %h dout %h rdata %h iom %b want all 0",
                         if0.bus_addr, if0.bus_dout, if0.rsp_rdata, if0.bus_iom);
    end
    t_valid0 = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", if0.req_ready); end
    @(negedge clk);
    checks++;
    if ({if0.req_ready, if0.bus_rd_n} !== 2'b11) begin
      errors++; $display("FAIL reset_no_accept: ready/rd_n got %b want 11", {if0.req_ready, if0.bus_rd_n});
    end
  endtask

  task automatic test_mem_read;
    int nlow = 0;
    fill_din(8'h11);
    din_tab[3] = 8'hA5;
    issue(1'b0, 2'b00, 1'b0, 20'hFC010, 8'h00, 6);
    checks++;
    if (addr_tr[1] !== 20'hFC010 || iom_tr[1] !== 1'b0) begin
      errors++; $display("FAIL mrd_addr: addr %h iom %b want FC010 0", addr_tr[1], iom_tr[1]);
    end
    for (int i = 1; i <= 6; i++) begin
      logic exp_rd = !(i == 2 || i == 3);
      if (rd_tr[i] == 1'b0) nlow++;
      checks++;
      if (rd_tr[i] !== exp_rd || wr_tr[i] !== 1'b1 || inta_tr[i] !== 1'b1) begin
        errors++; $display("FAIL mrd_strobe c%0d: rd/wr/inta %b%b%b want %b11", i, rd_tr[i], wr_tr[i], inta_tr[i], exp_rd);
      end
      checks++;
      if (val_tr[i] !== (i == 4) || rdy_tr[i] !== (i >= 5)) begin
        errors++; $display("FAIL mrd_handshake c%0d: valid %b ready %b want %b %b", i, val_tr[i], rdy_tr[i], (i == 4), (i >= 5));
      end
    end
    checks++;
    if (nlow != 2) begin errors++; $display("FAIL mrd_rd_len: got %0d want 2", nlow); end
    checks++;
    if (rdat_tr[4] !== 8'hA5) begin errors++; $display("FAIL mrd_rdata: got %h want a5", rdat_tr[4]); end
  endtask

  task automatic test_io_write;
    fill_din(8'hEE);
    issue(1'b0, 2'b11, 1'b0, 20'h00056, 8'h3C, 6);
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (addr_tr[i] !== 20'h00056 || iom_tr[i] !== 1'b1 || dout_tr[i] !== 8'h3C) begin
        errors++; $display("FAIL iow_bus c%0d: addr %h iom %b dout %h want 00056 1 3c", i, addr_tr[i], iom_tr[i], dout_tr[i]);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      logic exp_wr = !(i == 2 || i == 3);
      checks++;
      if (wr_tr[i] !== exp_wr || rd_tr[i] !== 1'b1 || val_tr[i] !== (i == 4) || rdat_tr[i] !== 8'hA5) begin
        errors++; $display("FAIL iow_cycle c%0d: wr %b rd %b valid %b rdata %h want %b 1 %b a5",
                           i, wr_tr[i], rd_tr[i], val_tr[i], rdat_tr[i], exp_wr, (i == 4));
      end
    end
  endtask

  task automatic test_io_read;
    fill_din(8'h00);
    din_tab[3] = 8'h77;
    issue(1'b0, 2'b10, 1'b0, 20'hABCDE, 8'h00, 5);
    checks++;
    if (addr_tr[2] !== 20'h0BCDE || iom_tr[2] !== 1'b1) begin
      errors++; $display("FAIL ior_addr: addr %h iom %b want 0bcde 1", addr_tr[2], iom_tr[2]);
    end
    checks++;
    if (dout_tr[2] !== 8'h3C) begin errors++; $display("FAIL ior_dout_held: got %h want 3c", dout_tr[2]); end
    checks++;
    if (rdat_tr[4] !== 8'h77 || val_tr[4] !== 1'b1) begin
      errors++; $display("FAIL ior_rdata: rdata %h valid %b want 77 1", rdat_tr[4], val_tr[4]);
    end
  endtask

  task automatic test_inta;
    fill_din(8'h33);
    din_tab[3] = 8'hFF;
    din_tab[9] = 8'h08;
    issue(1'b0, 2'b01, 1'b1, 20'h12345, 8'h99, 12);
    checks++;
    if (addr_tr[1] !== 20'h0 || iom_tr[1] !== 1'b0 || dout_tr[1] !== 8'h3C) begin
      errors++; $display("FAIL inta_bus: addr %h iom %b dout %h want 0 0 3c", addr_tr[1], iom_tr[1], dout_tr[1]);
    end
    for (int i = 1; i <= 12; i++) begin
      logic exp_inta = !(i == 2 || i == 3 || i == 8 || i == 9);
      checks++;
      if (inta_tr[i] !== exp_inta || rd_tr[i] !== 1'b1 || wr_tr[i] !== 1'b1) begin
        errors++; $display("FAIL inta_strobe c%0d: inta/rd/wr %b%b%b want %b11", i, inta_tr[i], rd_tr[i], wr_tr[i], exp_inta);
      end
      checks++;
      if (val_tr[i] !== (i == 10)) begin
        errors++; $display("FAIL inta_valid c%0d: got %b want %b", i, val_tr[i], (i == 10));
      end
    end
    checks++;
    if (rdat_tr[5] !== 8'h77) begin errors++; $display("FAIL inta_first_pulse_nocapture: got %h want 77", rdat_tr[5]); end
    checks++;
    if (rdat_tr[10] !== 8'h08) begin errors++; $display("FAIL inta_vector: got %h want 08", rdat_tr[10]); end
  endtask

  task automatic test_wait_states;
    fill_din(8'h00);
    issue(1'b1, 2'b01, 1'b0, 20'h01234, 8'h5A, 8);
    for (int i = 1; i <= 8; i++) begin
      logic exp_wr = !(i >= 2 && i <= 5);
      checks++;
      if (wr_tr[i] !== exp_wr || rdy_tr[i] !== (i >= 7) || val_tr[i] !== (i == 6)) begin
        errors++; $display("FAIL ws_cycle c%0d: wr %b ready %b valid %b want %b %b %b",
                           i, wr_tr[i], rdy_tr[i], val_tr[i], exp_wr, (i >= 7), (i == 6));
      end
    end
    checks++;
    if (addr_tr[6] !== 20'h01234 || dout_tr[6] !== 8'h5A || iom_tr[6] !== 1'b0) begin
      errors++; $display("FAIL ws_bus: addr %h dout %h iom %b want 01234 5a 0", addr_tr[6], dout_tr[6], iom_tr[6]);
    end
  endtask

  task automatic test_back_to_back;
    int first = -1;
    int second = -1;
    @(negedge clk);
    t_op = 2'b01; t_inta = 1'b0; t_addr = 20'h01234; t_wdata = 8'h5A;
    t_valid2 = 1'b1;
    for (int i = 0; i < 30 && second < 0; i++) begin
      if (if2.req_ready) begin
        if (first < 0) first = cyc;
        else           second = cyc;
      end
      @(negedge clk);
    end
    t_valid2 = 1'b0;
    checks++;
    if (first < 0 || second < 0 || (second - first) != 7) begin
      errors++; $display("FAIL b2b_spacing: got %0d (first %0d second %0d) want 7", second - first, first, second);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit bad = 1'b0;
    fill_din(8'h99);
    issue(1'b0, 2'b00, 1'b0, 20'h12345, 8'h00, 2);
    @(negedge clk);  // cycle k+3 = T3
    checks++;
    if (if0.bus_rd_n !== 1'b0) begin errors++; $display("FAIL rst_mid_in_t3: rd_n %b want 0", if0.bus_rd_n); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({if0.bus_rd_n, if0.bus_wr_n, if0.bus_inta_n, if0.rsp_valid, if0.req_ready} !== 5'b11100) begin
      errors++; $display("FAIL rst_mid_state: rd/wr/inta/valid/ready %b want 11100",
                         {if0.bus_rd_n, if0.bus_wr_n, if0.bus_inta_n, if0.rsp_valid, if0.req_ready});
    end
    checks++;
    if (if0.rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_mid_rdata: got %h want 00", if0.rsp_rdata); end
    rst = 1'b0;
    #1;
    checks++;
    if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", if0.req_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if0.rsp_valid !== 1'b0 || if0.bus_rd_n !== 1'b1 || if0.rsp_rdata !== 8'h00) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rst_mid_dropped: valid/rd_n/rdata changed after reset, want 0/1/00"); end
  endtask

  initial begin
    fill_din(8'h00);
    test_reset;
    test_mem_read;
    test_io_write;
    test_io_read;
    test_inta;
    test_wait_states;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
